fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter that bursts requester data into a downstream FIFO
// and tracks that FIFO's occupancy from its own writes and the consumer's pops.
module fifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic                     fifo_rd,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic                     fifo_wr,
  output logic [DW-1:0]            fifo_din,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     full,
  output logic                     empty
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [OW-1:0] OCC_MAX   = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_LAST  = OW'(DEPTH - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_n;
  logic [NREQ-1:0] gnt_n;
  logic [IW-1:0]   owner, owner_n;
  logic [IW-1:0]   last_winner, last_n;
  logic [IW-1:0]   winner, cand;
  logic [BW-1:0]   beat_cnt, beat_n;
  logic [OW-1:0]   occ_n;
  logic [DW-1:0]   owner_data;
  logic            space, pop, accept, found;

  assign space = (occ < OCC_MAX);
  assign pop   = fifo_rd && (occ != '0);
  assign occ_n = occ + OW'(accept) - OW'(pop);
  assign full  = (occ == OCC_MAX);
  assign empty = (occ == '0);

  // Search starts just past the previous owner so nobody wins twice while others wait.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(last_winner) + 1 + k) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) owner_data = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    last_n  = last_winner;
    beat_n  = beat_cnt;
    ack     = '0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (|req && space) begin
          state_n        = GRANT;
          gnt_n          = '0;
          gnt_n[winner]  = 1'b1;
          owner_n        = winner;
          beat_n         = '0;
        end
      end
      GRANT: begin
        if (req[owner] && space && !rst) begin
          accept     = 1'b1;
          ack[owner] = 1'b1;
          beat_n     = beat_cnt + BW'(1);
        end
        // A beat landing in the last free slot (with no pop) also ends the burst.
        if (!req[owner] ||
            (accept && ((beat_cnt == BEAT_LAST) || ((occ == OCC_LAST) && !pop)))) begin
          state_n = IDLE;
          gnt_n   = '0;
          last_n  = owner;
          beat_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      owner       <= '0;
      last_winner <= IW'(NREQ - 1);
      beat_cnt    <= '0;
      occ         <= '0;
      fifo_wr     <= 1'b0;
      fifo_din    <= '0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      owner       <= owner_n;
      last_winner <= last_n;
      beat_cnt    <= beat_n;
      occ         <= occ_n;
      fifo_wr     <= accept;
      if (accept) fifo_din <= owner_data;
    end
  end

endmodule
